// File: rtl/otp_chunk_assembler_if.sv
// Chunk-in / ciphertext-out handshake bundle for the OTP chunk assembler.
interface otp_chunk_assembler_if #(
  parameter int unsigned MSG_SIZE = 32,
  parameter int unsigned KEY_SIZE = 8
);
  logic                start;
  logic [KEY_SIZE-1:0] chunk_in;
  logic                chunk_valid;
  logic [KEY_SIZE-1:0] key_in;
  logic                chunk_ready;
  logic [MSG_SIZE-1:0] cipher_out;
  logic                cipher_valid;
  logic                cipher_ready;
  logic                busy;

  modport master (
    output start, chunk_in, chunk_valid, key_in, cipher_ready,
    input  chunk_ready, cipher_out, cipher_valid, busy
  );

  modport slave (
    input  start, chunk_in, chunk_valid, key_in, cipher_ready,
    output chunk_ready, cipher_out, cipher_valid, busy
  );
endinterface

// File: rtl/otp_chunk_assembler.sv
// XORs MSB-first plaintext chunks with pad chunks and assembles them into one
// ciphertext word, held with valid/ready until the consumer takes it.
module otp_chunk_assembler #(
  parameter int unsigned MSG_SIZE = 32,
  parameter int unsigned KEY_SIZE = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  otp_chunk_assembler_if.slave bus
);
  localparam int unsigned NCHUNK = MSG_SIZE / KEY_SIZE;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned HIST_W = MSG_SIZE - KEY_SIZE;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t              state;
  // Only the low MSG_SIZE-KEY_SIZE bits of the accumulator ever reach the
  // output, since the last chunk is merged straight into cipher_out.
  logic [HIST_W-1:0]   acc;
  logic [CNT_W-1:0]    cnt;
  logic [KEY_SIZE-1:0] pad_x;

  assign pad_x = bus.chunk_in ^ bus.key_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      acc              <= '0;
      cnt              <= '0;
      bus.chunk_ready  <= 1'b0;
      bus.cipher_out   <= '0;
      bus.cipher_valid <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc             <= '0;
            cnt             <= '0;
            state           <= COLLECT;
            bus.chunk_ready <= 1'b1;
            bus.busy        <= 1'b1;
          end
        end
        COLLECT: begin
          // start restarts the message; a chunk in the same cycle is dropped
          if (bus.start) begin
            acc <= '0;
            cnt <= '0;
          end else if (bus.chunk_valid) begin
            acc <= HIST_W'({acc, pad_x});
            if (cnt == LAST_IDX) begin
              state            <= DONE;
              bus.chunk_ready  <= 1'b0;
              bus.cipher_out   <= {acc, pad_x};
              bus.cipher_valid <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (bus.cipher_ready) begin
            state            <= IDLE;
            bus.cipher_out   <= '0;
            bus.cipher_valid <= 1'b0;
            bus.busy         <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          bus.chunk_ready  <= 1'b0;
          bus.cipher_out   <= '0;
          bus.cipher_valid <= 1'b0;
          bus.busy         <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_otp_chunk_assembler.sv
// Scoreboard bench for otp_chunk_assembler: directed messages push expected
// ciphertexts; a negedge monitor pops them on every valid/ready transfer.
module tb_otp_chunk_assembler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  otp_chunk_assembler_if #(.MSG_SIZE(32), .KEY_SIZE(8)) bus ();

  otp_chunk_assembler #(.MSG_SIZE(32), .KEY_SIZE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int transfers = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: output zero when idle, stability while waiting, ordered transfers.
  logic        prev_valid = 1'b0;
  logic        prev_xfer = 1'b0;
  logic [31:0] prev_out = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_xfer  = 1'b0;
    end else begin
      if (!bus.cipher_valid) chk("out_zero_when_invalid", bus.cipher_out, 32'h0);
      if (prev_valid && !prev_xfer) begin
        chk("valid_held", {31'h0, bus.cipher_valid}, 32'h1);
        chk("out_stable", bus.cipher_out, prev_out);
      end
      prev_xfer = 1'b0;
      if (bus.cipher_valid && bus.cipher_ready) begin
        transfers++;
        prev_xfer = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_cipher: got %h expected none", bus.cipher_out);
        end else begin
          chk("cipher_out", bus.cipher_out, exp_q.pop_front());
        end
      end
      prev_valid = bus.cipher_valid;
      prev_out   = bus.cipher_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] k, input int gap);
    for (int g = 0; g < gap; g++) tick();
    bus.chunk_in    = c;
    bus.key_in      = k;
    bus.chunk_valid = 1'b1;
    tick();
    bus.chunk_valid = 1'b0;
  endtask

  // Raise cipher_ready until the transfer completes, then confirm IDLE.
  task automatic take(input logic with_start);
    bit done = 1'b0;
    bus.cipher_ready = 1'b1;
    bus.start        = with_start;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      bus.start = 1'b0;
      if (!bus.cipher_valid) done = 1'b1;
    end
    bus.cipher_ready = 1'b0;
    chk("transfer_completes", {31'h0, done}, 32'h1);
    chk("idle_busy", {31'h0, bus.busy}, 32'h0);
    chk("idle_ready", {31'h0, bus.chunk_ready}, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'h0, bus.busy}, 32'h0);
    chk({tag, "_chunk_ready"}, {31'h0, bus.chunk_ready}, 32'h0);
    chk({tag, "_cipher_valid"}, {31'h0, bus.cipher_valid}, 32'h0);
    chk({tag, "_cipher_out"}, bus.cipher_out, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0;
    bus.chunk_in = '0;
    bus.key_in = '0;
    bus.chunk_valid = 1'b0;
    bus.cipher_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Basic message, key FF, 1-clock latency from last accept.
    exp_q.push_back(32'h21524110);
    do_start();
    chk("collect_ready", {31'h0, bus.chunk_ready}, 32'h1);
    send(8'hDE, 8'hFF, 0);
    send(8'hAD, 8'hFF, 0);
    send(8'hBE, 8'hFF, 0);
    chk("no_valid_before_last", {31'h0, bus.cipher_valid}, 32'h0);
    send(8'hEF, 8'hFF, 0);
    chk("valid_after_last", {31'h0, bus.cipher_valid}, 32'h1);
    take(1'b0);

    // Gaps of 0..3 cycles between chunks, key 00.
    exp_q.push_back(32'hDEADBEEF);
    do_start();
    send(8'hDE, 8'h00, 0);
    send(8'hAD, 8'h00, 1);
    send(8'hBE, 8'h00, 2);
    send(8'hEF, 8'h00, 3);
    take(1'b0);

    // Hold in DONE with start/chunk_valid noise, then ready together with start.
    exp_q.push_back(32'h11223344);
    do_start();
    send(8'h11, 8'h00, 0);
    send(8'h22, 8'h00, 0);
    send(8'h33, 8'h00, 0);
    send(8'h44, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      bus.start       = i[0];
      bus.chunk_valid = 1'b1;
      bus.chunk_in    = 8'h99;
      tick();
      chk("done_chunk_ready", {31'h0, bus.chunk_ready}, 32'h0);
      chk("done_hold_out", bus.cipher_out, 32'h11223344);
    end
    bus.start = 1'b0;
    bus.chunk_valid = 1'b0;
    take(1'b1);

    // Abort after two chunks; the chunk presented with start is dropped.
    exp_q.push_back(32'h3C4B5A69);
    do_start();
    send(8'h11, 8'h0F, 0);
    send(8'h22, 8'h0F, 0);
    bus.start = 1'b1;
    send(8'h77, 8'h0F, 0);
    bus.start = 1'b0;
    chk("abort_stays_collect", {31'h0, bus.chunk_ready}, 32'h1);
    send(8'h33, 8'h0F, 0);
    send(8'h44, 8'h0F, 0);
    send(8'h55, 8'h0F, 0);
    send(8'h66, 8'h0F, 0);
    take(1'b0);

    // Reset mid-message with every other input asserted.
    do_start();
    send(8'hAA, 8'h00, 0);
    send(8'hBB, 8'h00, 0);
    send(8'hCC, 8'h00, 0);
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.chunk_valid = 1'b1;
    bus.chunk_in = 8'hDD;
    bus.cipher_ready = 1'b1;
    tick();
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.chunk_valid = 1'b0;
    bus.cipher_ready = 1'b0;
    tick();
    check_reset_outputs("after_reset");
    exp_q.push_back(32'h01020304);
    do_start();
    send(8'h01, 8'h00, 0);
    send(8'h02, 8'h00, 0);
    send(8'h03, 8'h00, 0);
    send(8'h04, 8'h00, 0);
    take(1'b0);

    // chunk_valid in IDLE is ignored; start plus chunk AA in IDLE drops AA.
    send(8'h5A, 8'h00, 0);
    chk("idle_chunk_ignored", {31'h0, bus.busy}, 32'h0);
    exp_q.push_back(32'hB1B2B3B4);
    bus.start = 1'b1;
    send(8'hAA, 8'h00, 0);
    bus.start = 1'b0;
    chk("start_chunk_ready", {31'h0, bus.chunk_ready}, 32'h1);
    send(8'hB1, 8'h00, 0);
    send(8'hB2, 8'h00, 0);
    send(8'hB3, 8'h00, 0);
    chk("aa_not_counted", {31'h0, bus.cipher_valid}, 32'h0);
    send(8'hB4, 8'h00, 0);
    take(1'b0);

    repeat (3) tick();
    chk("transfer_count", 32'(transfers), 32'd6);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/otp_chunk_assembler.md
OTP_CHUNK_ASSEMBLER -- requirements
Module: otp_chunk_assembler

Interface
REQ-001 The block SHALL have parameter MSG_SIZE, default 32: plaintext/ciphertext width in bits, equal to the `MSG_SIZE constant.
REQ-002 The block SHALL have parameter KEY_SIZE, default 8: chunk and key width in bits, equal to the `KEY_SIZE constant; MSG_SIZE SHALL be an integer multiple of KEY_SIZE, giving NCHUNK = MSG_SIZE/KEY_SIZE and NCHUNK >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: begins a new message; chunk counter and accumulator clear.
REQ-006 The block SHALL have port chunk_in, input, KEY_SIZE bits: plaintext chunk from the upstream shifter, MSB-first order.
REQ-007 The block SHALL have port chunk_valid, input, 1 bit: chunk_in holds a valid chunk this cycle.
REQ-008 The block SHALL have port key_in, input, KEY_SIZE bits: pad chunk paired with chunk_in in the same cycle.
REQ-009 The block SHALL have port chunk_ready, output, 1 bit: the block accepts a chunk this cycle.
REQ-010 The block SHALL have port cipher_out, output, MSG_SIZE bits: assembled ciphertext.
REQ-011 The block SHALL have port cipher_valid, output, 1 bit: cipher_out is complete and stable.
REQ-012 The block SHALL have port cipher_ready, input, 1 bit: the downstream consumer accepts cipher_out.
REQ-013 The block SHALL have port busy, output, 1 bit: high in COLLECT or DONE.

Function
REQ-014 The FSM SHALL have states IDLE, COLLECT and DONE, with registered outputs only.
REQ-015 In IDLE, start=1 SHALL clear the accumulator and counter and go to COLLECT; chunk_valid in the same cycle SHALL be ignored.
REQ-016 chunk_ready SHALL be high exactly when the state is COLLECT; a chunk SHALL be accepted on a cycle with chunk_ready=1 and chunk_valid=1.
REQ-017 On acceptance, the accumulator SHALL become {acc[MSG_SIZE-KEY_SIZE-1:0], chunk_in ^ key_in}, so the first chunk lands in the MSBs, and the counter SHALL increment.
REQ-018 The counter SHALL be ceil(log2(NCHUNK)) bits wide, run 0..NCHUNK-1 and never wrap within a message.
REQ-019 Acceptance of chunk NCHUNK-1 SHALL move the state to DONE; cipher_valid=1 and cipher_out=final accumulator SHALL appear on the next cycle, giving a latency of 1 clock from the last accepted chunk.
REQ-020 In DONE, cipher_out and cipher_valid SHALL stay stable until cipher_ready=1; on that cycle the transfer completes, cipher_valid drops on the next edge, and the state returns to IDLE.
REQ-021 start in DONE SHALL be ignored; an unacknowledged ciphertext SHALL never be lost.
REQ-022 start in COLLECT SHALL abort the message, clear the accumulator and counter, and remain in COLLECT; a chunk presented in that same cycle SHALL be dropped.
REQ-023 chunk_valid outside COLLECT SHALL have no effect.
REQ-024 cipher_out SHALL be 0 whenever cipher_valid=0.
REQ-025 In DONE, cipher_ready=1 together with start=1 SHALL complete the transfer only, with start ignored.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, accumulator=0, counter=0, cipher_out=0, cipher_valid=0, chunk_ready=0, busy=0, from any state including mid-message and DONE.
REQ-027 Reset SHALL take priority over start, chunk_valid and cipher_ready in the same cycle.
REQ-028 A message interrupted by reset SHALL be discarded, with no partial cipher_valid.

Verification
REQ-029 Bench SHALL drive MSG_SIZE=32, KEY_SIZE=8, start, then chunks DE,AD,BE,EF each with key FF, then cipher_ready=1 -> cipher_valid 1 cycle after the EF accept, cipher_out=0x21524110, IDLE after the handshake.
REQ-030 Bench SHALL repeat 0xDEADBEEF with keys 00, with chunk_valid gaps of 0-3 cycles between chunks -> cipher_out=0xDEADBEEF, no chunk lost or duplicated.
REQ-031 Bench SHALL hold cipher_ready=0 for 5 cycles in DONE while pulsing start and chunk_valid -> cipher_out stable, chunk_ready=0, and 1 transfer when cipher_ready rises.
REQ-032 Bench SHALL pulse start after 2 chunks (11,22), then send 33,44,55,66 with key 0F -> cipher_out=0x3C4B5A69.
REQ-033 Bench SHALL assert rst_n=0 after 3 chunks, then a full message 01,02,03,04 with key 00 -> no cipher_valid before the reset, then cipher_out=0x01020304.
REQ-034 Bench SHALL assert start and chunk_valid together in IDLE with chunk AA -> AA not accepted, counter=0 in COLLECT.
